// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_pkg;
    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {IDLE, SHIFT} spi_slv_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with edge detect
// against the previous synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/SS_N/MOSI in the local clock domain,
// all four CPOL/CPHA modes, MSB first, multi-byte frames.
module spi_slave import spi_pkg::*; #(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              sclk_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              rx_done_tick_o,
    output logic              busy_o
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_slv_state_t    state_q, state_d;
    logic              start;
    logic              cpol_q, cpha_q;
    logic [DATA_W-1:0] tx_q, rx_q, rx_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              sclk_lvl, sclk_rise, sclk_fall;
    logic              ss_lvl, ss_rise, ss_fall;
    logic              mosi_lvl, mosi_rise, mosi_fall;
    logic              lead, trail, sample, drive, last_bit;
    logic              sync_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(ss_n_i),
        .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

    assign sync_unused = ^{sclk_lvl, ss_lvl, mosi_rise, mosi_fall};

    // Leading edge leaves the CPOL idle level; trailing edge returns to it.
    assign lead     = cpol_q ? sclk_fall : sclk_rise;
    assign trail    = cpol_q ? sclk_rise : sclk_fall;
    assign sample   = cpha_q ? trail : lead;
    assign drive    = cpha_q ? lead  : trail;
    assign last_bit = (cnt_q == CNT_W'(DATA_W-1));
    assign rx_next  = {rx_q[DATA_W-2:0], mosi_lvl};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE:  if (ss_fall) begin
                       state_d = SHIFT;
                       start   = 1'b1;
                   end
            SHIFT: if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpol_q         <= 1'b0;
            cpha_q         <= 1'b0;
            tx_q           <= '0;
            rx_q           <= '0;
            cnt_q          <= '0;
            miso_o         <= 1'b0;
            dout_o         <= '0;
            rx_done_tick_o <= 1'b0;
        end else begin
            rx_done_tick_o <= 1'b0;
            if (start) begin
                cpol_q <= cpol_i;
                cpha_q <= cpha_i;
                cnt_q  <= '0;
                rx_q   <= '0;
                // CPHA=0 must present the MSB before the first SCLK edge.
                if (cpha_i) begin
                    tx_q   <= din_i;
                    miso_o <= 1'b0;
                end else begin
                    tx_q   <= {din_i[DATA_W-2:0], 1'b0};
                    miso_o <= din_i[DATA_W-1];
                end
            end else if (state_q == SHIFT) begin
                if (sample) begin
                    rx_q <= rx_next;
                    if (last_bit) begin
                        dout_o         <= rx_next;
                        rx_done_tick_o <= 1'b1;
                        cnt_q          <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Reload happens in the tick cycle so the user can swap din_i on the tick.
                if (drive) begin
                    miso_o <= tx_q[DATA_W-1];
                    tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                end else if (rx_done_tick_o) begin
                    tx_q <= din_i;
                end
                if (ss_rise) begin
                    cnt_q  <= '0;
                    rx_q   <= '0;
                    miso_o <= 1'b0;
                end
            end
        end
    end

    assign busy_o    = (state_q == SHIFT);
    assign miso_oe_o = (state_q == SHIFT);
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the other end of the SPI link driven by the team's SPI master. Oversamples the external `sclk_i`, `ss_n_i` and `mosi_i` in the local `clk_i` domain. Shifts in one byte per 8 SCLK cycles while driving a local byte out on `miso_o`. Supports all four CPOL/CPHA modes, MSB first, and multi-byte frames while `ss_n_i` stays low.

## Interface
- `DATA_W`, default 8: bits per transfer.
- `SYNC_STAGES`, default 2: flops in each input synchronizer, minimum 2.
- `clk_i` in 1: system clock; must be at least 8× the SCLK frequency.
- `rst_i` in 1: reset, asynchronous and active-high; one clock domain only.
- `cpol_i` in 1: SCLK idle level; captured when a frame starts.
- `cpha_i` in 1: 0 = sample on leading edge, 1 = sample on trailing edge; captured when a frame starts.
- `din_i` in DATA_W: byte to transmit; sampled at frame start and in each `rx_done_tick_o` cycle.
- `sclk_i` in 1: SPI clock from the master; asynchronous to `clk_i`.
- `ss_n_i` in 1: active-low slave select; asynchronous to `clk_i`.
- `mosi_i` in 1: serial data from the master; asynchronous to `clk_i`.
- `miso_o` out 1: serial data to the master; 0 when not selected.
- `miso_oe_o` out 1: output enable for an external tristate; high while selected.
- `dout_o` out DATA_W: last fully received byte; held until the next byte completes.
- `rx_done_tick_o` out 1: one-cycle pulse when a byte completes.
- `busy_o` out 1: high while a frame is active.

## Operation
- State machine has two states.
  - IDLE → SHIFT on the synchronized falling edge of `ss_n`.
    - In that cycle: capture `cpol_i` and `cpha_i`, load the TX shift register from `din_i`, clear the bit counter, and set `busy_o` and `miso_oe_o`.
  - SHIFT → IDLE on the synchronized rising edge of `ss_n`.
  - `rst_i` forces IDLE.
- Leading edge is the SCLK transition away from the CPOL level; trailing edge is the return to it.
- Sample edge: leading edge if CPHA=0, trailing edge if CPHA=1.
  - Each sample event shifts the synchronized `mosi` into the RX register (MSB first) and increments the bit counter (0..DATA_W-1).
- Drive edge is the opposite edge; it presents the next TX bit on `miso_o`.
  - CPHA=0: `din_i[7]` appears on `miso_o` in the frame-start cycle, before any SCLK edge.
  - CPHA=1: `din_i[7]` appears on `miso_o` at the first leading edge.
- On the DATA_W-th sample event:
  - `dout_o` ← RX register including the bit just sampled, and `rx_done_tick_o`=1 for that cycle.
  - Bit counter wraps to 0.
  - TX register reloads from `din_i`, so the next byte's MSB goes out at the next drive edge.
- Frame ends by abort (`ss_n` rising before the DATA_W-th sample):
  - Discard the partial byte: no tick, `dout_o` unchanged.
  - Return to IDLE, and clear the counter and RX register.
- SCLK edges while in IDLE are ignored.
- Changes to `cpol_i`/`cpha_i` during SHIFT have no effect.
- If the DATA_W-th sample event and the `ss_n` rising edge are detected in the same cycle, the byte completes: tick asserted and `dout_o` updated, then IDLE.

## Timing
- Reset values:
  - `miso_o`=0, `miso_oe_o`=0, `busy_o`=0, `rx_done_tick_o`=0, `dout_o`=0.
  - Synchronizers cleared to idle levels: `ss_n`=1, `sclk`=0, `mosi`=0.
- Input-to-edge-detect latency is SYNC_STAGES+1 `clk_i` cycles, i.e. 3 at default.
- `miso_o` changes SYNC_STAGES+1 cycles after the drive edge at the pin.
  - Each SCLK half-period must be ≥ SYNC_STAGES+2 `clk_i` cycles.
- `rx_done_tick_o` asserts SYNC_STAGES+1 cycles after the DATA_W-th sample edge at the pin.
- Back-to-back frames need `ss_n_i` high for ≥ SYNC_STAGES+1 cycles.
- Reset asserted mid-frame returns to IDLE and clears all state immediately.
  - After reset releases, a frame starts only on a fresh `ss_n` falling edge.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_slv_state_t` {IDLE, SHIFT};
  - `SPI_DATA_W`=8;
  - `SPI_SYNC_STAGES`=2.
- Sub-module `spi_sync_edge`: parameterized synchronizer plus registered rise/fall detect.
  - Instantiated three times: `sclk`, `ss_n`, `mosi`; the `mosi` instance uses its level output only.

## Test plan
- Mode 0, master dvsr=64, master sends 0xA5, `din_i`=0x23 → `dout_o`=0xA5, master receives 0x23, exactly one `rx_done_tick_o`.
- Modes 1, 2, 3, each with master byte 0x3C and `din_i`=0xC3 → `dout_o`=0x3C and master reads 0xC3 in every mode.
- Two-byte frame with `ss_n` held low:
  - master sends 0x12 then 0x34;
  - `din_i` is 0x56, then 0x78 when the first tick fires;
  - required: ticks with `dout_o`=0x12 then 0x34, and master receives 0x56 then 0x78.
- Abort: `ss_n` raised after 4 SCLK cycles → no tick, `dout_o` keeps its previous value, next full frame with 0x81 → `dout_o`=0x81.
- `rst_i` pulsed mid-byte → all outputs return to reset values within the reset cycle; next frame with 0xF0 received correctly.
- `ss_n` high with SCLK toggling → `miso_o`=0, `miso_oe_o`=0, `busy_o`=0, no tick.
